dvi_tmds_encoder: RTL and testbench

- Three-channel DVI 1.0 TMDS 8b/10b encoder.
- Consumes the pixel stream from the VGA test-pattern/timing stage: 8-bit RGB, hsync, vsync, blank.
- Produces three 10-bit symbols per pixel clock for the downstream serializer/DDR output driving gpdi_dp.
- One encoder core is instantiated per colour; each core keeps its own running-disparity counter.

---
 rtl/dvi_tmds_encoder.sv | 144 ++++++++++++++
 tb/tb_dvi_tmds_encoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_tmds_encoder.sv
// Three-channel DVI TMDS 8b/10b encoder: two-stage pipeline per colour,
// each channel tracking its own running disparity.

module tmds_channel (
    input  logic       clk_pixel,
    input  logic       rstn,
    input  logic [7:0] i_data,
    input  logic [1:0] i_ctrl,
    input  logic       i_blank,
    output logic [9:0] o_symbol
);

    logic [3:0] w_dataOnes;
    logic       w_useXnor;
    logic [8:0] w_qm;
    logic [3:0] w_qmOnes;

    logic [8:0] r_qm;
    logic [3:0] r_qmOnes;
    logic [1:0] r_ctrl;
    logic       r_blank;

    logic [4:0] w_diff;
    logic [4:0] w_cntNext;
    logic [9:0] w_symbol;

    logic [4:0] r_cnt;
    logic [9:0] r_symbol;

    always_comb begin
        w_dataOnes = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_dataOnes = w_dataOnes + {3'd0, i_data[i]};
        end
        w_useXnor = (w_dataOnes > 4'd4) || ((w_dataOnes == 4'd4) && !i_data[0]);
        w_qm      = 9'd0;
        w_qm[0]   = i_data[0];
        for (int i = 1; i < 8; i++) begin
            w_qm[i] = w_useXnor ? ~(w_qm[i-1] ^ i_data[i]) : (w_qm[i-1] ^ i_data[i]);
        end
        w_qm[8]  = ~w_useXnor;
        w_qmOnes = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_qmOnes = w_qmOnes + {3'd0, w_qm[i]};
        end
    end

    // Reset parks stage 1 in blanking so the first post-release edge still emits a control token.
    always_ff @(posedge clk_pixel) begin
        if (!rstn) begin
            r_qm     <= 9'd0;
            r_qmOnes <= 4'd0;
            r_ctrl   <= 2'b00;
            r_blank  <= 1'b1;
        end else begin
            r_qm     <= w_qm;
            r_qmOnes <= w_qmOnes;
            r_ctrl   <= i_ctrl;
            r_blank  <= i_blank;
        end
    end

    // Disparity math is modulo-32; bit 4 of r_cnt is its sign. w_diff = N1 - N0.
    always_comb begin
        w_diff    = {r_qmOnes, 1'b0} - 5'd8;
        w_symbol  = 10'd0;
        w_cntNext = r_cnt;
        if (r_blank) begin
            case (r_ctrl)
                2'b00:   w_symbol = 10'b1101010100;
                2'b01:   w_symbol = 10'b0010101011;
                2'b10:   w_symbol = 10'b0101010100;
                default: w_symbol = 10'b1010101011;
            endcase
            w_cntNext = 5'd0;
        end else if ((r_cnt == 5'd0) || (r_qmOnes == 4'd4)) begin
            w_symbol  = {~r_qm[8], r_qm[8], (r_qm[8] ? r_qm[7:0] : ~r_qm[7:0])};
            w_cntNext = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if ((!r_cnt[4] && (r_qmOnes > 4'd4)) || (r_cnt[4] && (r_qmOnes < 4'd4))) begin
            w_symbol  = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cntNext = r_cnt + {3'd0, r_qm[8], 1'b0} - w_diff;
        end else begin
            w_symbol  = {1'b0, r_qm[8], r_qm[7:0]};
            w_cntNext = r_cnt + w_diff - {3'd0, ~r_qm[8], 1'b0};
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!rstn) begin
            r_cnt    <= 5'd0;
            r_symbol <= 10'b1101010100;
        end else begin
            r_cnt    <= w_cntNext;
            r_symbol <= w_symbol;
        end
    end

    assign o_symbol = r_symbol;

endmodule

module dvi_tmds_encoder (
    input  logic       clk_pixel,
    input  logic       rstn,
    input  logic [7:0] i_red,
    input  logic [7:0] i_green,
    input  logic [7:0] i_blue,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic       i_blank,
    output logic [9:0] o_red,
    output logic [9:0] o_green,
    output logic [9:0] o_blue
);

    // Only the blue channel carries sync; red and green always send token 00 while blanked.
    tmds_channel u_red (
        .clk_pixel (clk_pixel),
        .rstn      (rstn),
        .i_data    (i_red),
        .i_ctrl    (2'b00),
        .i_blank   (i_blank),
        .o_symbol  (o_red)
    );

    tmds_channel u_green (
        .clk_pixel (clk_pixel),
        .rstn      (rstn),
        .i_data    (i_green),
        .i_ctrl    (2'b00),
        .i_blank   (i_blank),
        .o_symbol  (o_green)
    );

    tmds_channel u_blue (
        .clk_pixel (clk_pixel),
        .rstn      (rstn),
        .i_data    (i_blue),
        .i_ctrl    ({i_vsync, i_hsync}),
        .i_blank   (i_blank),
        .o_symbol  (o_blue)
    );

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Directed and model-checked bench for dvi_tmds_encoder: reset, control tokens,
// disparity sequences, XNOR path, mid-stream reset and a random pixel stream.

module tb_dvi_tmds_encoder;

    logic       clk_pixel;
    logic       rstn;
    logic [7:0] i_red, i_green, i_blue;
    logic       i_hsync, i_vsync, i_blank;
    logic [9:0] o_red, o_green, o_blue;

    dvi_tmds_encoder dut (
        .clk_pixel (clk_pixel),
        .rstn      (rstn),
        .i_red     (i_red),
        .i_green   (i_green),
        .i_blue    (i_blue),
        .i_hsync   (i_hsync),
        .i_vsync   (i_vsync),
        .i_blank   (i_blank),
        .o_red     (o_red),
        .o_green   (o_green),
        .o_blue    (o_blue)
    );

    localparam logic [9:0] TOKEN00 = 10'h354;

    int passCount  = 0;
    int totalCount = 0;

    int         modelCnt [3];
    logic [9:0] expSym   [3][2];
    logic [7:0] histData [3][2];
    logic       histBlank [2];
    logic       expValid  [2];
    logic [9:0] obsRed, obsGreen, obsBlue;

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
        totalCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%03h, expected 0x%03h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [9:0] encodeModel(input int ch, input logic [7:0] d, input logic blank, input logic [1:0] ctrl);
        int         ones, n1, n0;
        logic       useXnor, qm8;
        logic [7:0] qm;
        logic [9:0] sym;
        if (blank) begin
            modelCnt[ch] = 0;
            case (ctrl)
                2'b00:   return 10'b1101010100;
                2'b01:   return 10'b0010101011;
                2'b10:   return 10'b0101010100;
                default: return 10'b1010101011;
            endcase
        end
        ones    = $countones(d);
        useXnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm[0]   = d[0];
        for (int i = 1; i < 8; i++) qm[i] = useXnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm8 = !useXnor;
        n1  = $countones(qm);
        n0  = 8 - n1;
        if (modelCnt[ch] == 0 || n1 == n0) begin
            sym = {~qm8, qm8, (qm8 ? qm : ~qm)};
            modelCnt[ch] = modelCnt[ch] + (qm8 ? (n1 - n0) : (n0 - n1));
        end else if ((modelCnt[ch] > 0 && n1 > n0) || (modelCnt[ch] < 0 && n0 > n1)) begin
            sym = {1'b1, qm8, ~qm};
            modelCnt[ch] = modelCnt[ch] + 2 * int'(qm8) + (n0 - n1);
        end else begin
            sym = {1'b0, qm8, qm};
            modelCnt[ch] = modelCnt[ch] + (n1 - n0) - 2 * int'(!qm8);
        end
        return sym;
    endfunction

    function automatic logic [7:0] decodeSymbol(input logic [9:0] s);
        logic [7:0] q, d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    // Each call observes the symbols for the pixel driven two calls earlier, then drives a new pixel.
    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                 input logic hs, input logic vs, input logic blank, input logic rstnVal);
        logic [7:0] d [3];
        @(negedge clk_pixel);
        obsRed   = o_red;
        obsGreen = o_green;
        obsBlue  = o_blue;
        if (expValid[1]) begin
            checkOutput("redModel",   obsRed,   expSym[0][1]);
            checkOutput("greenModel", obsGreen, expSym[1][1]);
            checkOutput("blueModel",  obsBlue,  expSym[2][1]);
            if (!histBlank[1]) begin
                checkOutput("redDecode",   {2'b00, decodeSymbol(obsRed)},   {2'b00, histData[0][1]});
                checkOutput("greenDecode", {2'b00, decodeSymbol(obsGreen)}, {2'b00, histData[1][1]});
                checkOutput("blueDecode",  {2'b00, decodeSymbol(obsBlue)},  {2'b00, histData[2][1]});
            end
        end
        for (int c = 0; c < 3; c++) begin
            expSym[c][1]   = expSym[c][0];
            histData[c][1] = histData[c][0];
        end
        histBlank[1] = histBlank[0];
        expValid[1]  = expValid[0];
        i_red   = r;
        i_green = g;
        i_blue  = b;
        i_hsync = hs;
        i_vsync = vs;
        i_blank = blank;
        rstn    = rstnVal;
        d[0] = r;
        d[1] = g;
        d[2] = b;
        if (!rstnVal) begin
            for (int c = 0; c < 3; c++) begin
                modelCnt[c]  = 0;
                expSym[c][0] = TOKEN00;
                expSym[c][1] = TOKEN00;
            end
            histBlank[0] = 1'b1;
            histBlank[1] = 1'b1;
            expValid[0]  = 1'b1;
            expValid[1]  = 1'b1;
        end else begin
            expSym[0][0] = encodeModel(0, r, blank, 2'b00);
            expSym[1][0] = encodeModel(1, g, blank, 2'b00);
            expSym[2][0] = encodeModel(2, b, blank, {vs, hs});
            for (int c = 0; c < 3; c++) histData[c][0] = d[c];
            histBlank[0] = blank;
            expValid[0]  = 1'b1;
        end
    endtask

    task automatic checkAllIdle(input string tag);
        checkOutput({tag, "Red"},   obsRed,   TOKEN00);
        checkOutput({tag, "Green"}, obsGreen, TOKEN00);
        checkOutput({tag, "Blue"},  obsBlue,  TOKEN00);
    endtask

    initial begin
        logic [9:0] tokenTable [4];
        logic [9:0] zeroTable  [4];
        int         blankLeft;
        logic [1:0] ctrl;

        tokenTable[0] = 10'h354;
        tokenTable[1] = 10'h0AB;
        tokenTable[2] = 10'h154;
        tokenTable[3] = 10'h2AB;
        zeroTable[0]  = 10'h100;
        zeroTable[1]  = 10'h3FF;
        zeroTable[2]  = 10'h100;
        zeroTable[3]  = 10'h3FF;
        expValid[0] = 1'b0;
        expValid[1] = 1'b0;
        histBlank[0] = 1'b1;
        histBlank[1] = 1'b1;
        rstn    = 1'b0;
        i_red   = 8'd0;
        i_green = 8'd0;
        i_blue  = 8'd0;
        i_hsync = 1'b0;
        i_vsync = 1'b0;
        i_blank = 1'b0;

        $display("[TB] reset with random active pixels");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
            if (k > 0) checkAllIdle("reset");
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
            checkAllIdle("postReset");
        end

        $display("[TB] control tokens");
        for (int k = 0; k < 6; k++) begin
            ctrl = (k < 4) ? 2'(k) : 2'b00;
            applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), ctrl[0], ctrl[1], 1'b1, 1'b1);
            if (k >= 2) begin
                checkOutput("tokenBlue",  obsBlue,  tokenTable[k-2]);
                checkOutput("tokenRed",   obsRed,   TOKEN00);
                checkOutput("tokenGreen", obsGreen, TOKEN00);
            end
        end

        $display("[TB] disparity on zeros");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
            if (k >= 2) checkOutput("zerosBlue", obsBlue, zeroTable[k-2]);
        end

        $display("[TB] XNOR path");
        applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("xnorGreen", obsGreen, 10'h200);
        checkOutput("xnorBlue",  obsBlue,  10'h100);

        $display("[TB] mid-stream reset");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, (k == 3) ? 1'b0 : 1'b1);
            if (k == 4 || k == 5) checkAllIdle("midReset");
            if (k == 6) checkOutput("midResetFirst", obsBlue, 10'h100);
            if (k == 7) checkOutput("midResetSecond", obsBlue, 10'h3FF);
        end

        $display("[TB] random stream");
        blankLeft = 0;
        for (int k = 0; k < 3000; k++) begin
            if (blankLeft == 0 && $urandom_range(99) < 4) blankLeft = int'($urandom_range(20, 1));
            applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                          (blankLeft > 0) ? 1'b1 : 1'b0, 1'b1);
            if (blankLeft > 0) blankLeft--;
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
